// File: rtl/ariane_pkg.sv
// Shared HPM definitions: event indices, selector layout, address map.
package ariane_pkg;

  localparam logic [7:0] HPM_EVT_NONE          = 8'd0;
  localparam logic [7:0] HPM_EVT_L1I_MISS      = 8'd1;
  localparam logic [7:0] HPM_EVT_L1D_MISS      = 8'd2;
  localparam logic [7:0] HPM_EVT_ITLB_MISS     = 8'd3;
  localparam logic [7:0] HPM_EVT_DTLB_MISS     = 8'd4;
  localparam logic [7:0] HPM_EVT_LOAD          = 8'd5;
  localparam logic [7:0] HPM_EVT_STORE         = 8'd6;
  localparam logic [7:0] HPM_EVT_EXCEPTION     = 8'd7;
  localparam logic [7:0] HPM_EVT_EXCEPTION_RET = 8'd8;
  localparam logic [7:0] HPM_EVT_BRANCH_JUMP   = 8'd9;
  localparam logic [7:0] HPM_EVT_CALL          = 8'd10;
  localparam logic [7:0] HPM_EVT_RET           = 8'd11;
  localparam logic [7:0] HPM_EVT_MIS_PREDICT   = 8'd12;
  localparam logic [7:0] HPM_EVT_SB_FULL       = 8'd13;
  localparam logic [7:0] HPM_EVT_IF_EMPTY      = 8'd14;

  localparam int unsigned HPM_SEL_STOP = 61;
  localparam int unsigned HPM_SEL_OFEN = 62;
  localparam int unsigned HPM_SEL_OF   = 63;

  localparam logic [7:0] HPM_ADDR_CNT     = 8'h00;
  localparam logic [7:0] HPM_ADDR_SEL     = 8'h20;
  localparam logic [7:0] HPM_ADDR_INHIBIT = 8'h40;
  localparam logic [7:0] HPM_ADDR_OVF     = 8'h41;

  typedef struct packed {
    logic        of;
    logic        ofen;
    logic        stop;
    logic [52:0] rsvd;
    logic [7:0]  evt;
  } hpm_sel_t;

  // Reserved selector bits always read back as zero.
  function automatic hpm_sel_t hpm_sel_from_data(input logic [63:0] d);
    hpm_sel_t s;
    s      = '0;
    s.evt  = d[7:0];
    s.stop = d[HPM_SEL_STOP];
    s.ofen = d[HPM_SEL_OFEN];
    s.of   = d[HPM_SEL_OF];
    return s;
  endfunction

endpackage

// File: rtl/hpm_counters_event_counter.sv
// One programmable counter: event mux, accumulate, sticky overflow and write handling.
module hpm_event_counter
  import ariane_pkg::*;
#(
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NrEvents     = 16,
  parameter int unsigned IncWidth     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NrEvents*IncWidth-1:0] ev,
  input  logic                         inhibit,
  input  logic                         cnt_we,
  input  logic                         sel_we,
  input  logic [63:0]                  wdata,
  output logic [63:0]                  cnt,
  output hpm_sel_t                     sel
);

  localparam int unsigned SumW = CounterWidth + 1;

  logic [CounterWidth-1:0] cnt_q;
  hpm_sel_t                sel_q;
  logic [IncWidth-1:0]     inc;
  logic [SumW-1:0]         sum;
  logic                    unused_wdata;

  always_comb begin
    inc = '0;
    for (int unsigned e = 0; e < NrEvents; e++) begin
      if (sel_q.evt == 8'(e + 1)) inc = ev[e*IncWidth +: IncWidth];
    end
    if (inhibit || (sel_q.stop && sel_q.of)) inc = '0;
    sum = {1'b0, cnt_q} + SumW'(inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      if (cnt_we) cnt_q <= wdata[CounterWidth-1:0];
      else        cnt_q <= sum[CounterWidth-1:0];
      // A selector write overrides a same-cycle hardware overflow.
      if (sel_we)                           sel_q    <= hpm_sel_from_data(wdata);
      else if (!cnt_we && sum[CounterWidth]) sel_q.of <= 1'b1;
    end
  end

  assign cnt          = 64'(cnt_q);
  assign sel          = sel_q;
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/hpm_counters.sv
// HPM top: event sample stage, inhibit mask, address decode, read mux, overflow IRQ.
module hpm_counters
  import ariane_pkg::*;
#(
  parameter int unsigned NrCounters   = 8,
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NrEvents     = 16,
  parameter int unsigned IncWidth     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         debug_mode_i,
  input  logic [7:0]                   addr_i,
  input  logic                         we_i,
  input  logic [63:0]                  data_i,
  output logic [63:0]                  data_o,
  input  logic [NrEvents*IncWidth-1:0] event_inc_i,
  output logic                         irq_o
);

  logic [NrEvents*IncWidth-1:0] ev_q;
  logic [NrCounters-1:0]        inhibit_q;
  logic [NrCounters-1:0]        of_vec;
  logic [NrCounters-1:0]        irq_vec;
  logic [63:0]                  cnt_rd [NrCounters];
  hpm_sel_t                     sel_rd [NrCounters];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ev_q      <= '0;
      inhibit_q <= '0;
      irq_o     <= 1'b0;
    end else begin
      ev_q  <= debug_mode_i ? '0 : event_inc_i;
      irq_o <= |irq_vec;
      if (we_i && addr_i == HPM_ADDR_INHIBIT) inhibit_q <= data_i[NrCounters-1:0];
    end
  end

  for (genvar i = 0; i < NrCounters; i++) begin : g_cnt
    hpm_event_counter #(
      .CounterWidth(CounterWidth),
      .NrEvents    (NrEvents),
      .IncWidth    (IncWidth)
    ) u_cnt (
      .clk    (clk_i),
      .rst    (rst_i),
      .ev     (ev_q),
      .inhibit(inhibit_q[i]),
      .cnt_we (we_i && addr_i == HPM_ADDR_CNT + 8'(i)),
      .sel_we (we_i && addr_i == HPM_ADDR_SEL + 8'(i)),
      .wdata  (data_i),
      .cnt    (cnt_rd[i]),
      .sel    (sel_rd[i])
    );
    assign of_vec[i]  = sel_rd[i].of;
    assign irq_vec[i] = sel_rd[i].of & sel_rd[i].ofen;
  end

  always_comb begin
    data_o = '0;
    if (addr_i == HPM_ADDR_INHIBIT) data_o = 64'(inhibit_q);
    if (addr_i == HPM_ADDR_OVF)     data_o = 64'(of_vec);
    for (int unsigned i = 0; i < NrCounters; i++) begin
      if (addr_i == HPM_ADDR_CNT + 8'(i)) data_o = cnt_rd[i];
      if (addr_i == HPM_ADDR_SEL + 8'(i)) data_o = sel_rd[i];
    end
  end

endmodule
